// File: rtl/div_32bit_seq_if.sv
// Handshake bundle between the execute stage and the sequential divider.
// master: issuing/consuming side (pipeline), slave: the divider itself.
interface div_32bit_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, op, dividend, divisor, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, dividend, divisor, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/div_32bit_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// op: 00=DIV 01=DIVU 10=REM 11=REMU. One 33-bit trial subtraction per CALC edge.
// Optional macro DIV_EARLY_OUT_EN: finish in one edge when |divisor| > |dividend|.
module div_32bit_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   div_32bit_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t          state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [XLEN-1:0] rem_q, rem_n;
   logic [XLEN-1:0] quo_q, quo_n;
   logic [XLEN-1:0] dvs_q, dvs_n;
   logic            rem_sel, rem_sel_n;
   logic            qsign, qsign_n;
   logic            rsign, rsign_n;
   logic [XLEN-1:0] result_q, result_n;

   logic            signed_op;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div_zero, sgn_ovf;
   logic [XLEN:0]   rem_sh, trial;
   logic [XLEN-1:0] q_fix, r_fix;

   // Operand magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude.
   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.dividend[XLEN-1];
   assign b_neg     = signed_op & bus.divisor[XLEN-1];
   assign abs_a     = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
   assign abs_b     = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
   assign div_zero  = (bus.divisor == '0);
   assign sgn_ovf   = signed_op && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.divisor == '1);

   // Shifted partial remainder carries the quotient MSB; bit XLEN of trial is its sign.
   assign rem_sh = {rem_q, quo_q[XLEN-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};

   assign q_fix = qsign ? (~quo_q + 1'b1) : quo_q;
   assign r_fix = rsign ? (~rem_q + 1'b1) : rem_q;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;

   // Next-state and datapath updates; defaults hold every register.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rem_n     = rem_q;
      quo_n     = quo_q;
      dvs_n     = dvs_q;
      rem_sel_n = rem_sel;
      qsign_n   = qsign;
      rsign_n   = rsign;
      result_n  = result_q;

      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  rem_sel_n = bus.op[1];
                  qsign_n   = a_neg ^ b_neg;
                  rsign_n   = a_neg;
                  if (div_zero) begin
                     result_n = bus.op[1] ? bus.dividend : '1;
                     state_n  = DONE;
                  end else if (sgn_ovf) begin
                     result_n = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     state_n  = DONE;
`ifdef DIV_EARLY_OUT_EN
                  end else if (abs_b > abs_a) begin
                     result_n = bus.op[1] ? bus.dividend : '0;
                     state_n  = DONE;
`endif
                  end else begin
                     cnt_n   = CNT_W'(XLEN - 1);
                     rem_n   = '0;
                     quo_n   = abs_a;
                     dvs_n   = abs_b;
                     state_n = CALC;
                  end
               end
            end
            CALC: begin
               if (!trial[XLEN]) begin
                  rem_n = trial[XLEN-1:0];
                  quo_n = {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_n = rem_sh[XLEN-1:0];
                  quo_n = {quo_q[XLEN-2:0], 1'b0};
               end
               cnt_n = cnt - 1'b1;
               if (cnt == '0) begin
                  state_n = FIXUP;
               end
            end
            FIXUP: begin
               result_n = rem_sel ? r_fix : q_fix;
               state_n  = DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         rem_sel  <= 1'b0;
         qsign    <= 1'b0;
         rsign    <= 1'b0;
         result_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rem_q    <= rem_n;
         quo_q    <= quo_n;
         dvs_q    <= dvs_n;
         rem_sel  <= rem_sel_n;
         qsign    <= qsign_n;
         rsign    <= rsign_n;
         result_q <= result_n;
      end
   end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_div_32bit_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   div_32bit_seq_if #(.XLEN(32)) bus ();

   div_32bit_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      logic [31:0] ma, mb;
      ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
      mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) return 1;
`else
      if (mb > ma) return 34;
`endif
      return 34;
   endfunction

   // Issue one op, count edges from the accept edge (=1) until out_valid.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int n;
      chk({tag, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
      bus.op       = op;
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 1;
      chk({tag, " in_ready busy"}, {31'd0, bus.in_ready}, 32'd0);
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(model_lat(op, a, b)));
      chk({tag, " result"}, bus.result, model(op, a, b));
      if (bus.out_ready) begin
         tick();
         chk({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] ra, rb;
      logic [1:0]  rop;

      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;

      // reset values
      tick();
      tick();
      chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst result", bus.result, 32'd0);
      rst = 1'b0;
      tick();

      // directed arithmetic
      run_op(2'b01, 32'd100, 32'd7, "DIVU 100/7");
      run_op(2'b11, 32'd100, 32'd7, "REMU 100/7");
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "REM 7/-2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
      run_op(2'b01, 32'd5, 32'd0, "DIVU 5/0");
      run_op(2'b10, 32'd5, 32'd0, "REM 5/0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
      run_op(2'b01, 32'd3, 32'd10, "DIVU 3/10");
      run_op(2'b10, 32'hFFFF_FFFD, 32'd10, "REM -3/10");
      run_op(2'b01, 32'h8000_0000, 32'd1, "DIVU min/1");
      run_op(2'b00, 32'h8000_0000, 32'd2, "DIV min/2");

      // random operations
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 4))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'd0 - 32'($urandom_range(1, 15));
            3: rb = 32'hFFFF_FFFF;
            default: rb = ra >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         run_op(rop, ra, rb, "random");
      end

      // backpressure: DONE holds while out_ready is low
      bus.out_ready = 1'b0;
      run_op(2'b01, 32'd1000, 32'd3, "DIVU bp");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp result", bus.result, 32'd333);
         chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);

      // flush 5 edges into a fresh CALC
      bus.op       = 2'b00;
      bus.dividend = 32'd12345;
      bus.divisor  = 32'hFFFF_FFEF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush in_ready", {31'd0, bus.in_ready}, 32'd1);

      // in_valid coinciding with flush in IDLE is not accepted
      bus.op       = 2'b01;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd0;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      chk("flush+valid in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("flush+valid out_valid", {31'd0, bus.out_valid}, 32'd0);
      run_op(2'b00, 32'hFFFF_FF9C, 32'd7, "DIV after flush");

      // reset mid-CALC
      held = bus.result;
      chk("pre-rst result nonzero", {31'd0, (held != 32'd0)}, 32'd1);
      bus.op       = 2'b01;
      bus.dividend = 32'd77777;
      bus.divisor  = 32'd13;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst result", bus.result, 32'd0);
      rst = 1'b0;
      tick();
      run_op(2'b11, 32'd77777, 32'd13, "REMU after rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
